// File: rtl/starfield_mixer.sv
// Starfield mixer: tints/floors/twinkles star intensity and composites it under the foreground layer.
// Optional odd-line scanline dimming is built when STARFIELD_MIXER_SCANLINE_EN is defined.
module starfield_mixer #(
    parameter logic [7:0] TINT_R       = 8'hFF,
    parameter logic [7:0] TINT_G       = 8'hFF,
    parameter logic [7:0] TINT_B       = 8'hFF,
    parameter logic [7:0] TWINKLE_RATE = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       vblank,
    input  logic       hblank,
    input  logic       sf_on,
    input  logic [7:0] sf_star,
    input  logic       fg_on,
    input  logic [7:0] fg_r,
    input  logic [7:0] fg_g,
    input  logic [7:0] fg_b,
    input  logic [2:0] addr,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_vblank,
    output logic       out_hblank
);

    logic            r_star_en;
    logic            r_twinkle_en;
    logic [7:0]      r_rate;
    logic [7:0]      r_floor;
    logic [2:0][7:0] r_tint;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_star_en    <= 1'b1;
            r_twinkle_en <= 1'b1;
            r_rate       <= TWINKLE_RATE;
            r_floor      <= 8'd0;
            r_tint[0]    <= TINT_R;
            r_tint[1]    <= TINT_G;
            r_tint[2]    <= TINT_B;
        end else if (write) begin
            case (addr)
                3'd0: begin
                    r_star_en    <= data_in[0];
                    r_twinkle_en <= data_in[1];
                end
                3'd1: r_rate    <= data_in;
                3'd2: r_tint[0] <= data_in;
                3'd3: r_tint[1] <= data_in;
                3'd4: r_tint[2] <= data_in;
                3'd5: r_floor   <= data_in;
                default: ;
            endcase
        end
    end

    // Frame tick on the vblank rising edge; the rate register value before any same-cycle write is used.
    logic       r_vb_prev;
    logic [7:0] r_frame_cnt;
    logic [2:0] r_phase;
    logic       w_tick;
    logic [8:0] w_cnt_inc;

    assign w_tick    = en & vblank & ~r_vb_prev;
    assign w_cnt_inc = {1'b0, r_frame_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vb_prev   <= 1'b1;
            r_frame_cnt <= 8'd0;
            r_phase     <= 3'd0;
        end else begin
            if (en) r_vb_prev <= vblank;
            if (w_tick) begin
                if ((r_rate != 8'd0) && (w_cnt_inc >= {1'b0, r_rate})) begin
                    r_frame_cnt <= 8'd0;
                    r_phase     <= r_phase + 3'd1;
                end else begin
                    r_frame_cnt <= w_cnt_inc[7:0];
                end
            end
        end
    end

`ifdef STARFIELD_MIXER_SCANLINE_EN
    logic r_scan_en;
    logic r_hb_prev;
    logic r_line_odd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_en <= 1'b0;
        end else if (write && (addr == 3'd0)) begin
            r_scan_en <= data_in[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hb_prev  <= 1'b0;
            r_line_odd <= 1'b0;
        end else if (en) begin
            r_hb_prev <= hblank;
            if (vblank) r_line_odd <= 1'b0;
            else if (r_hb_prev && !hblank) r_line_odd <= ~r_line_odd;
        end
    end
`endif

    // Stage 1 intensity: floor first, then the twinkle halving for the matching brightness band.
    logic [7:0] w_base;
    logic       w_halve;
    logic [7:0] w_int;

    assign w_base  = (sf_star >= r_floor) ? sf_star : r_floor;
    assign w_halve = r_twinkle_en && (sf_star[7:5] == r_phase);
    assign w_int   = w_halve ? {1'b0, w_base[7:1]} : w_base;

    logic r_s1_vis;
    logic r_s1_fg_on;
    logic r_s1_hb;
    logic r_s1_vb;
    logic r_s1_dim;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vis   <= 1'b0;
            r_s1_fg_on <= 1'b0;
            r_s1_hb    <= 1'b1;
            r_s1_vb    <= 1'b1;
            r_s1_dim   <= 1'b0;
        end else if (en) begin
            r_s1_vis   <= sf_on & r_star_en;
            r_s1_fg_on <= fg_on;
            r_s1_hb    <= hblank;
            r_s1_vb    <= vblank;
`ifdef STARFIELD_MIXER_SCANLINE_EN
            r_s1_dim   <= r_scan_en & r_line_odd;
`else
            r_s1_dim   <= 1'b0;
`endif
        end
    end

    logic r_out_hb;
    logic r_out_vb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_hb <= 1'b1;
            r_out_vb <= 1'b1;
        end else if (en) begin
            r_out_hb <= r_s1_hb;
            r_out_vb <= r_s1_vb;
        end
    end

    logic [2:0][7:0] w_fg;
    logic [2:0][7:0] w_out;

    assign w_fg[0] = fg_r;
    assign w_fg[1] = fg_g;
    assign w_fg[2] = fg_b;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [15:0] w_prod;
            logic [7:0]  w_star_c;
            logic [7:0]  w_sel;
            logic [7:0]  w_mix;
            logic [7:0]  r_s1_fg;
            logic [7:0]  r_s1_star;
            logic [7:0]  r_out;

            // Tint is applied in stage 1 so a CPU write never reaches a pixel already sampled.
            assign w_prod   = {8'd0, w_int} * {8'd0, r_tint[gi]};
            assign w_star_c = 8'(w_prod >> 8);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_fg   <= 8'd0;
                    r_s1_star <= 8'd0;
                end else if (en) begin
                    r_s1_fg   <= w_fg[gi];
                    r_s1_star <= w_star_c;
                end
            end

            always_comb begin
                w_sel = 8'd0;
                if (r_s1_hb || r_s1_vb) w_sel = 8'd0;
                else if (r_s1_fg_on)    w_sel = r_s1_fg;
                else if (r_s1_vis)      w_sel = r_s1_star;
            end

            assign w_mix = r_s1_dim ? (w_sel - {2'b00, w_sel[7:2]}) : w_sel;

            always_ff @(posedge clk) begin
                if (rst)     r_out <= 8'd0;
                else if (en) r_out <= w_mix;
            end

            assign w_out[gi] = r_out;
        end
    endgenerate

    assign out_r      = w_out[0];
    assign out_g      = w_out[1];
    assign out_b      = w_out[2];
    assign out_hblank = r_out_hb;
    assign out_vblank = r_out_vb;

endmodule

// File: doc/starfield_mixer.md
Name: starfield_mixer

Overview:
Downstream stage of the starfield generator. Consumes its per-pixel star alpha (sf_on) and brightness (sf_star) and applies a CPU-programmable tint, a brightness floor and a frame-based twinkle. It then composites the result underneath the foreground (character/sprite) layer and produces final 8-bit-per-channel RGB for the video output path. Fixed pipeline of 2 pixel-enable steps.

Parameters:
TINT_R, 8'hFF, reset value of red tint register
TINT_G, 8'hFF, reset value of green tint register
TINT_B, 8'hFF, reset value of blue tint register
TWINKLE_RATE, 8'd4, reset value of twinkle-rate register (frames per phase step)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  pixel enable (ce_pix); the pipeline advances only when high
vblank  in  1  vertical blank, pixel-aligned with sf_on/sf_star
hblank  in  1  horizontal blank, pixel-aligned
sf_on  in  1  star present
sf_star  in  8  star brightness
fg_on  in  1  foreground pixel opaque
fg_r / fg_g / fg_b  in  8 each  foreground colour
addr  in  3  CPU register address
data_in  in  8  CPU write data
write  in  1  CPU write strobe, one clk
out_r / out_g / out_b  out  8 each  composited colour
out_vblank / out_hblank  out  1 each  blanks delayed to match colour

Behaviour:
- Registers, written on any clk with write=1 regardless of en:
  - 0 ctrl: bit0 star_en, bit1 twinkle_en
  - 1 twinkle_rate
  - 2/3/4 tint R/G/B
  - 5 floor
  - 6, 7 ignored
- Reset values:
  - ctrl=8'h03, floor=0, tints/rate from parameters.
  - Outputs all 0; blanks out = 1.
  - twinkle phase=0, frame counter=0, pipeline flushed (valid stages read as blanked).
- Write timing: a write in cycle N affects the first pixel sampled at stage 1 on a later en cycle (>N).
- Frame tick: on the rising edge of vblank, sampled on an en cycle.
  - frame_cnt increments.
  - When frame_cnt+1 >= twinkle_rate: frame_cnt <= 0 and phase <= phase+1 (3-bit, wraps 7->0).
  - twinkle_rate=0 freezes the phase.
- Stage 1 (on en): register inputs and compute intensity I.
  - I = max(sf_star, floor).
  - If twinkle_en and sf_star[7:5]==phase, I = I>>1.
  - star_vis = sf_on & star_en.
- Stage 2 (on en), per channel:
  - star_c = (I * tint_c) >> 8, 16-bit product, upper byte. 255*255 gives 254; any operand of 0 gives 0.
  - If hblank|vblank (delayed): out = 0.
  - Else if fg_on: out = fg.
  - Else if star_vis: out = star_c.
  - Else: out = 0.
- Latency: exactly 2 en pulses from input to out_*. Blanks are delayed identically. Outputs hold while en=0.
- rst mid-frame: pipeline flushes to blank within the same clk; the following en pixels proceed normally.
- Simultaneous write and frame tick: both take effect. A rate written in the same cycle is used from the next tick.

Optional Feature:
STARFIELD_MIXER_SCANLINE_EN
- Defined:
  - A line-parity bit toggles on each hblank falling edge (en cycles) and clears on vblank high.
  - On odd lines, stage 2 applies out = out - (out>>2) to both foreground and star pixels.
  - ctrl bit2 enables the effect; reset value 0.
- Undefined: no parity logic, ctrl bit2 ignored, output identical to the base behaviour.

Test Plan:
- Reset, then sf_on=1, sf_star=8'h80, tints FF, fg_on=0, no twinkle -> out=8'h7F on all channels exactly 2 en pulses later.
- Write tint R=8'h40, G=0, B=FF with sf_star=8'hFF -> out_r=8'h3F, out_g=0, out_b=8'hFE.
- Write floor=8'h20 with sf_star=8'h05 and sf_on=1 -> channel=8'h1F. With sf_on=0 -> channel=0.
- Rate=2, twinkle_en=1, 4 vblank rising edges -> phase=2. A star with sf_star=8'h50 outputs I=8'h28 (halved). A star with 8'h90 is not halved.
- fg_on=1 with fg=8'h12/34/56 over a star pixel -> out=12/34/56. Assert hblank -> out=0 and out_hblank=1 with 2-pixel delay.
- rst asserted mid-line with en=1 -> next clk all out=0, blanks=1. Pixels after release appear 2 en pulses later.
